// File: rtl/ext_obi_copy_master_pkg.sv
// Shared types, register map and FSM encoding for the OBI word-copy initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ext_obi_copy_master_pkg;

  // Register-bus request/response (one reg_demux slot)
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  // OBI initiator request/response
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Byte offsets; only addr[4:2] takes part in decode
  localparam logic [4:0] SRC_OFFSET  = 5'h00;
  localparam logic [4:0] DST_OFFSET  = 5'h04;
  localparam logic [4:0] LEN_OFFSET  = 5'h08;
  localparam logic [4:0] CTRL_OFFSET = 5'h0C;
  localparam logic [4:0] STAT_OFFSET = 5'h10;

  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
  localparam int unsigned CTRL_ABORT_BIT   = 2;
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_ABORTED_BIT = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } copy_state_e;

endpackage

// File: rtl/ext_obi_copy_master_regs.sv
// Register file and reg_req decode: SRC/DST/LEN/CTRL/STAT, start/abort pulses out.
// Latency: rsp combinational, register updates visible the cycle after the write.
// Backpressure: none, ready is returned in the same cycle as valid.
module ext_obi_copy_regs
  import ext_obi_copy_master_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  reg_req_t             reg_req_i,
  output reg_rsp_t             reg_rsp_o,
  input  logic                 busy_i,
  input  logic                 done_set_i,
  input  logic                 aborted_set_i,
  input  logic                 status_clr_i,
  output logic                 start_o,
  output logic                 abort_o,
  output logic [31:0]          src_o,
  output logic [31:0]          dst_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 irq_en_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic [2:0] word_idx;
  logic       sel_src, sel_dst, sel_len, sel_ctrl, sel_stat, wr;
  logic       unused_req_bits;

  assign word_idx = reg_req_i.addr[4:2];
  assign sel_src  = (word_idx == SRC_OFFSET[4:2]);
  assign sel_dst  = (word_idx == DST_OFFSET[4:2]);
  assign sel_len  = (word_idx == LEN_OFFSET[4:2]);
  assign sel_ctrl = (word_idx == CTRL_OFFSET[4:2]);
  assign sel_stat = (word_idx == STAT_OFFSET[4:2]);
  assign wr       = reg_req_i.valid & reg_req_i.write;

  // Byte strobes and the bits outside the decoded window carry no meaning here
  assign unused_req_bits = ^{reg_req_i.wstrb, reg_req_i.addr[31:5], reg_req_i.addr[1:0]};

  assign start_o = wr & sel_ctrl & reg_req_i.wdata[CTRL_START_BIT];
  assign abort_o = wr & sel_ctrl & reg_req_i.wdata[CTRL_ABORT_BIT];

  // Next-state of the register file; hardware status set has the last word over W1C
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    if (wr && !busy_i) begin
      if (sel_src) src_d = {reg_req_i.wdata[31:2], 2'b00};
      if (sel_dst) dst_d = {reg_req_i.wdata[31:2], 2'b00};
      if (sel_len) len_d = reg_req_i.wdata[LEN_WIDTH-1:0];
    end
    if (wr && sel_ctrl) irq_en_d = reg_req_i.wdata[CTRL_IRQ_EN_BIT];
    if (status_clr_i) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
    if (wr && sel_stat) begin
      if (reg_req_i.wdata[STAT_DONE_BIT])    done_d    = 1'b0;
      if (reg_req_i.wdata[STAT_ABORTED_BIT]) aborted_d = 1'b0;
    end
    if (done_set_i)    done_d    = 1'b1;
    if (aborted_set_i) aborted_d = 1'b1;
  end

  // Register file state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Combinational read mux and decode error for unmapped offsets
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    unique case (1'b1)
      sel_src:  reg_rsp_o.rdata = src_q;
      sel_dst:  reg_rsp_o.rdata = dst_q;
      sel_len:  reg_rsp_o.rdata = 32'(len_q);
      sel_ctrl: reg_rsp_o.rdata = {30'b0, irq_en_q, 1'b0};
      sel_stat: reg_rsp_o.rdata = {29'b0, aborted_q, done_q, busy_i};
      default:  reg_rsp_o.error = reg_req_i.valid;
    endcase
  end

  assign src_o     = src_q;
  assign dst_o     = dst_q;
  assign len_o     = len_q;
  assign irq_en_o  = irq_en_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;

endmodule

// File: rtl/ext_obi_copy_master.sv
// Register-programmed OBI initiator copying LEN words SRC->DST, one read then one write each.
// Latency: 4 cycles per word with zero-wait gnt and 1-cycle rvalid.
// Backpressure: req held stable until gnt; rvalid only accepted in wait states.
module ext_obi_copy_master
  import ext_obi_copy_master_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  master_req_o,
  input  obi_resp_t master_resp_i,
  output logic      done_intr_o
);

  copy_state_e          state_q, state_d;
  logic [31:0]          cur_src_q, cur_src_d;
  logic [31:0]          cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;
  logic                 abort_pend_q, abort_pend_d;

  logic                 start, abort, irq_en, done, aborted, busy, abort_now;
  logic                 done_set, aborted_set, status_clr;
  logic [31:0]          cfg_src, cfg_dst;
  logic [LEN_WIDTH-1:0] cfg_len;

  assign busy      = (state_q != IDLE);
  // An abort landing on the final response still marks the copy as aborted
  assign abort_now = abort_pend_q | abort;

  ext_obi_copy_regs #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_regs (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .reg_req_i     (reg_req_i),
    .reg_rsp_o     (reg_rsp_o),
    .busy_i        (busy),
    .done_set_i    (done_set),
    .aborted_set_i (aborted_set),
    .status_clr_i  (status_clr),
    .start_o       (start),
    .abort_o       (abort),
    .src_o         (cfg_src),
    .dst_o         (cfg_dst),
    .len_o         (cfg_len),
    .irq_en_o      (irq_en),
    .done_o        (done),
    .aborted_o     (aborted)
  );

  // Copy FSM: next state, working-copy datapath and OBI request outputs
  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    abort_pend_d = abort_pend_q;
    master_req_o = '0;
    done_set     = 1'b0;
    aborted_set  = 1'b0;
    status_clr   = 1'b0;

    if (busy && abort) abort_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            cur_src_d    = cfg_src;
            cur_dst_d    = cfg_dst;
            cnt_d        = cfg_len;
            abort_pend_d = 1'b0;
            status_clr   = 1'b1;
            state_d      = RD_REQ;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      RD_REQ: begin
        master_req_o.req  = 1'b1;
        master_req_o.we   = 1'b0;
        master_req_o.be   = 4'hF;
        master_req_o.addr = cur_src_q;
        if (master_resp_i.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_resp_i.rvalid) begin
          data_d  = master_resp_i.rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        master_req_o.req   = 1'b1;
        master_req_o.we    = 1'b1;
        master_req_o.be    = 4'hF;
        master_req_o.addr  = cur_dst_q;
        master_req_o.wdata = data_q;
        if (master_resp_i.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (master_resp_i.rvalid) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          cnt_d     = cnt_q - LEN_WIDTH'(1);
          if ((cnt_q == LEN_WIDTH'(1)) || abort_now) begin
            done_set     = 1'b1;
            aborted_set  = abort_now;
            abort_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign done_intr_o = done & irq_en;

  logic unused_aborted;
  assign unused_aborted = aborted;

endmodule

// File: tb/tb_ext_obi_copy_master.sv
// Directed bench for ext_obi_copy_master: register table plus copy sequences.
// Latency: n/a.
// Backpressure: memory model inserts configurable gnt stalls and rvalid delays.
module tb_ext_obi_copy_master;
  import ext_obi_copy_master_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  reg_req_t  reg_req = '0;
  reg_rsp_t  reg_rsp;
  obi_req_t  mreq;
  obi_resp_t mresp = '0;
  logic      done_intr;

  ext_obi_copy_master #(.LEN_WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .reg_req_i     (reg_req),
    .reg_rsp_o     (reg_rsp),
    .master_req_o  (mreq),
    .master_resp_i (mresp),
    .done_intr_o   (done_intr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addrs [$];
  int          rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
  int          gnt_max = 0, rv_min = 1, rv_max = 1;
  int          stall_left = 0, rv_wait = 0;
  bit          pending = 0, stalled = 0;
  logic [31:0] pend_rdata;
  obi_req_t    held;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // OBI target: responds on negedges so the DUT samples on the next posedge
  task automatic mem_model();
    forever begin
      @(negedge clk);
      mresp.gnt    = 1'b0;
      mresp.rvalid = 1'b0;
      if (!rst_n) begin
        pending = 0;
        stalled = 0;
      end else if (pending) begin
        if (rv_wait == 0) begin
          mresp.rvalid = 1'b1;
          mresp.rdata  = pend_rdata;
          pending      = 0;
        end else rv_wait--;
      end else if (mreq.req) begin
        req_cycles++;
        if (stalled) begin
          chk("obi_stable_addr",  mreq.addr,  held.addr);
          chk("obi_stable_we",    32'(mreq.we), 32'(held.we));
          chk("obi_stable_wdata", mreq.wdata, held.wdata);
        end
        if (stall_left == 0) begin
          mresp.gnt = 1'b1;
          if (mreq.we) begin
            mem[mreq.addr] = mreq.wdata;
            wr_cnt++;
          end else begin
            rd_addrs.push_back(mreq.addr);
            pend_rdata = mem_rd(mreq.addr);
            rd_cnt++;
          end
          pending    = 1;
          rv_wait    = $urandom_range(rv_max, rv_min) - 1;
          stall_left = $urandom_range(gnt_max, 0);
          stalled    = 0;
        end else begin
          stall_left--;
          stalled = 1;
          held    = mreq;
        end
      end else begin
        stalled = 0;
      end
    end
  endtask

  task automatic reg_acc(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
    @(negedge clk);
    reg_req.valid = 1'b1;
    reg_req.write = wr;
    reg_req.addr  = addr;
    reg_req.wdata = wdata;
    reg_req.wstrb = 4'hF;
    #1;
    rdata = reg_rsp.rdata;
    err   = reg_rsp.error;
    chk("reg_ready", 32'(reg_rsp.ready), 32'd1);
    @(posedge clk);
    #1;
    reg_req.valid = 1'b0;
    reg_req.write = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        e;
    reg_acc(1'b1, addr, wdata, rd, e);
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] rdata);
    logic e;
    reg_acc(1'b0, addr, 32'd0, rdata, e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic [31:0] st;
    st = 32'd1;
    for (int i = 0; i < budget && st[0]; i++) reg_rd(32'h10, st);
    chk(name, 32'(st[0]), 32'd0);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    reg_wr(32'h00, s);
    reg_wr(32'h04, d);
    reg_wr(32'h08, n);
    reg_wr(32'h0C, 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] rd, rd2;
    logic        e;
    int          rb, wb, qb, rc;

    vecs[0]  = '{0, 32'h00, 32'h0,         32'h0,        0, "rst_src"};
    vecs[1]  = '{0, 32'h04, 32'h0,         32'h0,        0, "rst_dst"};
    vecs[2]  = '{0, 32'h08, 32'h0,         32'h0,        0, "rst_len"};
    vecs[3]  = '{0, 32'h0C, 32'h0,         32'h0,        0, "rst_ctrl"};
    vecs[4]  = '{0, 32'h10, 32'h0,         32'h0,        0, "rst_stat"};
    vecs[5]  = '{1, 32'h00, 32'h12345677,  32'h0,        0, "wr_src"};
    vecs[6]  = '{0, 32'h00, 32'h0,         32'h12345674, 0, "src_align"};
    vecs[7]  = '{1, 32'h04, 32'hABCDEF03,  32'h0,        0, "wr_dst"};
    vecs[8]  = '{0, 32'h04, 32'h0,         32'hABCDEF00, 0, "dst_align"};
    vecs[9]  = '{1, 32'h08, 32'hFFFF0005,  32'h0,        0, "wr_len"};
    vecs[10] = '{0, 32'h08, 32'h0,         32'h00000005, 0, "len_mask"};
    vecs[11] = '{1, 32'h0C, 32'h00000002,  32'h0,        0, "wr_irq_en"};
    vecs[12] = '{0, 32'h0C, 32'h0,         32'h00000002, 0, "ctrl_rd_irq"};
    vecs[13] = '{1, 32'h0C, 32'h00000000,  32'h0,        0, "wr_ctrl0"};
    vecs[14] = '{0, 32'h0C, 32'h0,         32'h00000000, 0, "ctrl_rd0"};
    vecs[15] = '{0, 32'h14, 32'h0,         32'h0,        1, "bad_rd14"};
    vecs[16] = '{1, 32'h18, 32'h1,         32'h0,        1, "bad_wr18"};
    vecs[17] = '{0, 32'h1C, 32'h0,         32'h0,        1, "bad_rd1c"};

    fork mem_model(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mreq.req), 32'd0);
    chk("rst_intr", 32'(done_intr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register-map table
    for (int i = 0; i < 18; i++) begin
      reg_acc(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e);
      if (!vecs[i].wr) chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
    end

    // 1) zero-wait LEN=4: 16 cycles, 8 transactions
    rb = rd_cnt; wb = wr_cnt;
    reg_wr(32'h00, 32'h1000);
    reg_wr(32'h04, 32'h2000);
    reg_wr(32'h08, 32'd4);
    reg_wr(32'h0C, 32'h1);
    repeat (15) @(posedge clk);
    reg_rd(32'h10, rd);
    chk("t1_stat_busy_c15", rd, 32'h1);
    reg_rd(32'h10, rd);
    chk("t1_stat_done_c16", rd, 32'h2);
    chk("t1_txn_count", 32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd8);
    for (int i = 0; i < 4; i++)
      chk("t1_dst_word", mem_rd(32'h2000 + 4 * i), pat(32'h1000 + 4 * i));
    reg_rd(32'h00, rd);
    chk("t1_src_kept", rd, 32'h1000);

    // 2) random stalls, LEN=32
    gnt_max = 5; rv_min = 1; rv_max = 3;
    start_copy(32'h3000, 32'h4000, 32'd32);
    wait_idle("t2_timeout", 3000);
    for (int i = 0; i < 32; i++)
      chk("t2_dst_word", mem_rd(32'h4000 + 4 * i), pat(32'h3000 + 4 * i));
    reg_rd(32'h10, rd);
    chk("t2_stat", rd, 32'h2);
    gnt_max = 0; rv_min = 1; rv_max = 1;

    // 3) LEN=0 start: no traffic, DONE, interrupt gated by IRQ_EN
    reg_wr(32'h10, 32'h6);
    reg_wr(32'h08, 32'd0);
    rc = req_cycles;
    reg_wr(32'h0C, 32'h1);
    repeat (3) @(posedge clk);
    reg_rd(32'h10, rd);
    chk("t3_stat", rd, 32'h2);
    chk("t3_intr_off", 32'(done_intr), 32'd0);
    chk("t3_no_req", 32'(req_cycles), 32'(rc));
    reg_wr(32'h0C, 32'h2);
    chk("t3_intr_on", 32'(done_intr), 32'd1);
    reg_wr(32'h10, 32'h2);
    chk("t3_intr_w1c", 32'(done_intr), 32'd0);
    reg_wr(32'h0C, 32'h3);
    chk("t3_intr_start", 32'(done_intr), 32'd1);
    reg_wr(32'h0C, 32'h0);
    chk("t3_intr_irq_off", 32'(done_intr), 32'd0);
    chk("t3_no_req_end", 32'(req_cycles), 32'(rc));

    // 4) abort after the 3rd write grant
    rb = rd_cnt; wb = wr_cnt;
    start_copy(32'h5000, 32'h6000, 32'd100);
    for (int i = 0; i < 2000 && (wr_cnt - wb) < 3; i++) @(posedge clk);
    chk("t4_wait_wr3", 32'(wr_cnt - wb >= 3), 32'd1);
    reg_wr(32'h0C, 32'h4);
    wait_idle("t4_timeout", 200);
    reg_rd(32'h10, rd);
    chk("t4_stat", rd, 32'h6);
    chk("t4_copies_3or4", 32'((wr_cnt - wb) == 3 || (wr_cnt - wb) == 4), 32'd1);
    chk("t4_rd_eq_wr", 32'(rd_cnt - rb), 32'(wr_cnt - wb));

    // 5) source address wraps at 4 GiB
    qb = rd_addrs.size();
    start_copy(32'hFFFFFFF8, 32'h7000, 32'd3);
    wait_idle("t5_timeout", 200);
    chk("t5_nreads", 32'(rd_addrs.size() - qb), 32'd3);
    if (rd_addrs.size() >= qb + 3) begin
      chk("t5_addr0", rd_addrs[qb],     32'hFFFFFFF8);
      chk("t5_addr1", rd_addrs[qb + 1], 32'hFFFFFFFC);
      chk("t5_addr2", rd_addrs[qb + 2], 32'h00000000);
    end
    chk("t5_dst_wrap", mem_rd(32'h7008), pat(32'h0));

    // 6a) config writes and START while busy
    rb = rd_cnt; wb = wr_cnt;
    start_copy(32'h1000, 32'h8000, 32'd10);
    reg_wr(32'h00, 32'hDEAD0000);
    reg_wr(32'h08, 32'd7);
    reg_wr(32'h0C, 32'h1);
    reg_rd(32'h00, rd);
    chk("t6_src_locked", rd, 32'h1000);
    reg_rd(32'h08, rd);
    chk("t6_len_locked", rd, 32'd10);
    wait_idle("t6_timeout", 300);
    chk("t6_wr_count", 32'(wr_cnt - wb), 32'd10);
    chk("t6_rd_count", 32'(rd_cnt - rb), 32'd10);

    // 6b) W1C on the cycle DONE is set: set wins
    reg_wr(32'h08, 32'd2);
    reg_wr(32'h0C, 32'h1);
    repeat (7) @(posedge clk);
    reg_wr(32'h10, 32'h2);
    reg_rd(32'h10, rd);
    chk("t6_w1c_race", rd, 32'h2);
    reg_wr(32'h10, 32'h2);
    reg_rd(32'h10, rd2);
    chk("t6_w1c_later", rd2, 32'h0);

    // 6c) reset while a write request is pending
    reg_wr(32'h08, 32'd4);
    reg_wr(32'h0C, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_in_wr_req", {30'b0, mreq.req, mreq.we}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(mreq.req), 32'd0);
    reg_rd(32'h10, rd);
    chk("t6_rst_stat", rd, 32'h0);
    reg_rd(32'h00, rd);
    chk("t6_rst_src", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_post_rst_idle", 32'(mreq.req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
